// File: rtl/tag_allocator_pkg.sv
// Shared types and sizing for the physical-register tag allocator.
// Tag states, tag/SqN widths and the SqN age comparison.
package tag_allocator_pkg;

  localparam int NUM_TAGS   = 64;
  localparam int NUM_ARCH   = 32;
  localparam int WIDTH_UOPS = 2;
  localparam int WIDTH_COM  = 2;
  localparam int TAG_W      = $clog2(NUM_TAGS);
  localparam int SQN_W      = 6;
  localparam int CNT_W      = 7;

  typedef enum logic [1:0] {
    FREE,
    RSV,
    SPEC,
    COMM
  } tag_state_t;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [SQN_W-1:0] sqn_t;

  // a is strictly younger than b under wrapping SqN arithmetic
  function automatic logic is_younger(sqn_t a, sqn_t b);
    sqn_t d;
    d = a - b;
    return !d[SQN_W-1] && (d != '0);
  endfunction

endpackage

// File: rtl/tag_allocator_pick.sv
// Find-first-set over the FREE bitmap, starting at a given index,
// skipping tags already claimed by earlier slots this cycle.
module tag_pick_first
  import tag_allocator_pkg::*;
(
  input  logic [NUM_TAGS-1:0] map_i,
  input  tag_t                start_i,
  input  logic [NUM_TAGS-1:0] excl_i,
  output logic                found_o,
  output tag_t                idx_o
);

  logic [NUM_TAGS-1:0] cand;
  tag_t                j;

  assign cand = map_i & ~excl_i;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      j = start_i + tag_t'(i);
      if (!found_o && cand[j]) begin
        found_o = 1'b1;
        idx_o   = j;
      end
    end
  end

endmodule

// File: rtl/tag_allocator.sv
// Physical tag manager: per-tag FREE/RSV/SPEC/COMM state, pre-reserved
// rename slots. TAG_ALLOC_RR_SEARCH_EN selects rotating free-tag search.
module tag_allocator
  import tag_allocator_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH_UOPS-1:0]  IN_allocReq,
  input  sqn_t [WIDTH_UOPS-1:0]  IN_allocSqN,
  output tag_t [WIDTH_UOPS-1:0]  OUT_tag,
  output logic [WIDTH_UOPS-1:0]  OUT_tagValid,
  output logic                   OUT_stall,
  input  logic [WIDTH_COM-1:0]   IN_commitValid,
  input  tag_t [WIDTH_COM-1:0]   IN_commitTag,
  input  logic [WIDTH_COM-1:0]   IN_freeValid,
  input  tag_t [WIDTH_COM-1:0]   IN_freeTag,
  input  logic                   IN_branchTaken,
  input  sqn_t                   IN_branchSqN,
  output logic [CNT_W-1:0]       OUT_freeCount
);

  tag_state_t st_q  [NUM_TAGS];
  tag_state_t st_d  [NUM_TAGS];
  sqn_t       sqn_q [NUM_TAGS];
  sqn_t       sqn_d [NUM_TAGS];

  tag_t [WIDTH_UOPS-1:0] slot_q, slot_d;
  logic [WIDTH_UOPS-1:0] vld_q, vld_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_TAGS-1:0]   free_map;
  logic [WIDTH_UOPS-1:0] use_w, need_w, found_w;
  tag_t [WIDTH_UOPS-1:0] pick_w;
  tag_t                  start_w;

  // Recovery drops allocation; empty or consumed slots refill
  assign use_w  = IN_allocReq & vld_q & {WIDTH_UOPS{!IN_branchTaken}};
  assign need_w = ~vld_q | use_w;

  // Tags that turn FREE this edge are only eligible next edge
  always_comb begin
    free_map = '0;
    for (int t = 0; t < NUM_TAGS; t++)
      free_map[t] = (st_q[t] == FREE);
  end

`ifdef TAG_ALLOC_RR_SEARCH_EN
  tag_t ptr_q, ptr_d;

  assign start_w = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    for (int s = 0; s < WIDTH_UOPS; s++)
      if (need_w[s] && found_w[s])
        ptr_d = pick_w[s] + tag_t'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
`else
  assign start_w = '0;
`endif

  for (genvar s = 0; s < WIDTH_UOPS; s++) begin : g_pick
    logic [NUM_TAGS-1:0] excl;
    logic [NUM_TAGS-1:0] excl_nxt;

    if (s == 0) begin : g_first
      assign excl = '0;
    end else begin : g_chain
      assign excl = g_pick[s-1].excl_nxt;
    end

    tag_pick_first u_pick (
      .map_i   (free_map),
      .start_i (start_w),
      .excl_i  (excl),
      .found_o (found_w[s]),
      .idx_o   (pick_w[s])
    );

    assign excl_nxt = excl |
      (need_w[s] ? (NUM_TAGS'(1) << pick_w[s]) : '0);
  end

  always_comb begin
    st_d   = st_q;
    sqn_d  = sqn_q;
    slot_d = slot_q;
    vld_d  = vld_q;
    cnt_d  = '0;

    for (int c = 0; c < WIDTH_COM; c++)
      if (IN_commitValid[c] && st_q[IN_commitTag[c]] == SPEC)
        st_d[IN_commitTag[c]] = COMM;

    // Squash sees commits from this edge, so committed tags survive
    if (IN_branchTaken)
      for (int t = 0; t < NUM_TAGS; t++)
        if (st_d[t] == SPEC && is_younger(sqn_q[t], IN_branchSqN))
          st_d[t] = FREE;

    for (int c = 0; c < WIDTH_COM; c++)
      if (IN_freeValid[c] && st_q[IN_freeTag[c]] == COMM)
        st_d[IN_freeTag[c]] = FREE;

    for (int s = 0; s < WIDTH_UOPS; s++)
      if (use_w[s]) begin
        st_d[slot_q[s]]  = SPEC;
        sqn_d[slot_q[s]] = IN_allocSqN[s];
      end

    for (int s = 0; s < WIDTH_UOPS; s++)
      if (need_w[s]) begin
        vld_d[s]  = found_w[s];
        slot_d[s] = found_w[s] ? pick_w[s] : '0;
        if (found_w[s])
          st_d[pick_w[s]] = RSV;
      end

    for (int t = 0; t < NUM_TAGS; t++)
      cnt_d = cnt_d + CNT_W'(st_d[t] == FREE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        st_q[t]  <= (t < NUM_ARCH) ? COMM : FREE;
        sqn_q[t] <= '0;
      end
      slot_q <= '0;
      vld_q  <= '0;
      cnt_q  <= CNT_W'(NUM_TAGS - NUM_ARCH);
    end else begin
      st_q   <= st_d;
      sqn_q  <= sqn_d;
      slot_q <= slot_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
    end
  end

  assign OUT_tag       = slot_q;
  assign OUT_tagValid  = vld_q;
  assign OUT_stall     = !(&vld_q);
  assign OUT_freeCount = cnt_q;

endmodule
